// File: rtl/uart_rx_frame_ctrl.sv
// rtl/uart_rx_frame_ctrl.sv - UART RX frame controller: start detect, 3-sample vote, deserialise, start/stop checks
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  par_err,
  output logic                  sampled_bit,
  output logic [DATA_WIDTH-1:0] P_data,
  output logic                  parity_check_en,
  output logic                  data_valid,
  output logic                  strt_glitch,
  output logic                  stp_err,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0]         LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] MIN_PS   = PRESCALE_W'(8);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [PRESCALE_W-1:0] ps_lat;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic                  s0;
  logic                  s1;
  logic                  pe_flag;
  logic                  par_frame;

  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] last;
  logic                  bit_end;
  logic                  maj;

  assign half    = ps_lat >> 1;
  assign last    = ps_lat - ONE;
  assign bit_end = (edge_cnt == last);
  assign maj     = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= IDLE;
      ps_lat          <= MIN_PS;
      edge_cnt        <= '0;
      bit_cnt         <= '0;
      s0              <= 1'b1;
      s1              <= 1'b1;
      pe_flag         <= 1'b0;
      par_frame       <= 1'b0;
      sampled_bit     <= 1'b1;
      P_data          <= '0;
      parity_check_en <= 1'b0;
      data_valid      <= 1'b0;
      strt_glitch     <= 1'b0;
      stp_err         <= 1'b0;
    end else begin
      parity_check_en <= 1'b0;
      data_valid      <= 1'b0;
      strt_glitch     <= 1'b0;
      stp_err         <= 1'b0;

      // Bit timing and the three mid-bit samples run identically in every framed state.
      if (state != IDLE) begin
        edge_cnt <= bit_end ? '0 : edge_cnt + ONE;
        if (edge_cnt == half - ONE) s0 <= RX_IN;
        if (edge_cnt == half)       s1 <= RX_IN;
        if (edge_cnt == half + ONE) sampled_bit <= maj;
      end

      case (state)
        IDLE: begin
          if (!RX_IN) begin
            state     <= START;
            edge_cnt  <= ONE;
            ps_lat    <= (prescale < MIN_PS) ? MIN_PS : prescale;
            pe_flag   <= 1'b0;
            par_frame <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            if (sampled_bit) begin
              strt_glitch <= 1'b1;
              state       <= IDLE;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end
        DATA: begin
          if (bit_end) begin
            P_data <= {sampled_bit, P_data[DATA_WIDTH-1:1]};
            if (bit_cnt == LAST_BIT) begin
              state     <= PAR_EN ? PARITY : STOP;
              par_frame <= PAR_EN;
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
            end
          end
        end
        PARITY: begin
          // Registered, so raise it one edge early to cover the bit's last cycle.
          if (edge_cnt == last - ONE) parity_check_en <= 1'b1;
          if (bit_end) state <= STOP;
        end
        STOP: begin
          if (edge_cnt == '0 && par_frame) pe_flag <= par_err;
          if (bit_end) begin
            if (!sampled_bit)  stp_err    <= 1'b1;
            else if (!pe_flag) data_valid <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb/tb_uart_rx_frame_ctrl.sv - directed scoreboard bench for uart_rx_frame_ctrl
module tb_uart_rx_frame_ctrl;

  localparam int K_DV   = 0;
  localparam int K_GL   = 1;
  localparam int K_STP  = 2;
  localparam int K_PCE  = 3;
  localparam int K_NONE = 7;

  typedef struct {
    int         kind;
    int         cyc;
    logic [8:0] data;
    logic       pe;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic [5:0] prescale = 6'd8;
  logic       par_err;
  logic       sampled_bit;
  logic [7:0] P_data;
  logic       parity_check_en;
  logic       data_valid;
  logic       strt_glitch;
  logic       stp_err;
  logic       busy;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  sb[$];
  logic pe_pending = 1'b0;
  logic pe_exp = 1'b0;

  uart_rx_frame_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
    .par_err(par_err), .sampled_bit(sampled_bit), .P_data(P_data),
    .parity_check_en(parity_check_en), .data_valid(data_valid),
    .strt_glitch(strt_glitch), .stp_err(stp_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Even-parity checker standing in for the downstream block.
  always @(posedge clk) begin
    if (!rst)                 par_err <= 1'b0;
    else if (parity_check_en) par_err <= (^P_data) ^ sampled_bit;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at cyc %0d", tag, obs, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    int  obs_kind;
    ev_t e;
    if (rst) begin
      if (pe_pending) begin
        check("par_err_stop_edge0", {31'd0, par_err}, {31'd0, pe_exp});
        pe_pending = 1'b0;
      end
      if (data_valid | strt_glitch | stp_err | parity_check_en) begin
        obs_kind = data_valid ? K_DV : strt_glitch ? K_GL : stp_err ? K_STP : K_PCE;
        if (sb.size() == 0) begin
          check("unexpected_strobe", obs_kind, K_NONE);
        end else begin
          e = sb.pop_front();
          check("strobe_kind", obs_kind, e.kind);
          check("strobe_cycle", cyc, e.cyc);
          if (e.kind == K_PCE) begin
            check("pce_bit_data", {23'd0, sampled_bit, P_data}, {23'd0, e.data});
            pe_pending = 1'b1;
            pe_exp     = e.pe;
          end else if (e.kind != K_GL) begin
            check("strobe_P_data", {24'd0, P_data}, {24'd0, e.data[7:0]});
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_ev(input int kind, input int c, input logic [8:0] d, input logic pe);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.data = d;
    e.pe   = pe;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input int ps, input logic pen,
                            input logic pbit, input logic sbit, input int glitch_bit);
    int c0;
    int f;
    prescale = 6'(ps);
    PAR_EN   = pen;
    c0 = cyc;
    f  = (pen ? 11 : 10) * ps;
    if (pen) push_ev(K_PCE, c0 + 10 * ps - 1, {pbit, d}, (^d) ^ pbit);
    if (!sbit)                    push_ev(K_STP, c0 + f, {1'b0, d}, 1'b0);
    else if (!pen || !((^d) ^ pbit)) push_ev(K_DV, c0 + f, {1'b0, d}, 1'b0);
    RX_IN = 1'b0;
    tick(ps);
    for (int i = 0; i < 8; i++) begin
      RX_IN = d[i];
      if (i == glitch_bit) begin
        tick(ps / 2);
        RX_IN = ~d[i];
        tick(1);
        RX_IN = d[i];
        tick(ps - ps / 2 - 1);
      end else begin
        tick(ps);
      end
    end
    if (pen) begin
      RX_IN = pbit;
      tick(ps);
    end
    RX_IN = sbit;
    tick(ps);
    RX_IN = 1'b1;
  endtask

  initial begin
    tick(3);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sampled_bit", {31'd0, sampled_bit}, 32'd1);
    check("rst_P_data", {24'd0, P_data}, 32'd0);
    check("rst_strobes", {28'd0, data_valid, strt_glitch, stp_err, parity_check_en}, 32'd0);
    rst = 1'b1;
    tick(4);

    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1);
    tick(4);
    check("sb_empty_a5", sb.size(), 0);

    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, -1);
    tick(4);
    check("sb_empty_3c_par_ok", sb.size(), 0);

    send_frame(8'h3C, 16, 1'b1, 1'b1, 1'b1, -1);
    tick(4);
    check("sb_empty_3c_par_bad", sb.size(), 0);

    prescale = 6'd16;
    PAR_EN   = 1'b0;
    push_ev(K_GL, cyc + 16, 9'd0, 1'b0);
    RX_IN = 1'b0;
    tick(3);
    RX_IN = 1'b1;
    tick(20);
    check("sb_empty_glitch", sb.size(), 0);
    check("idle_after_glitch", {31'd0, busy}, 32'd0);

    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b0, -1);
    tick(4);
    check("sb_empty_stp", sb.size(), 0);

    send_frame(8'h0F, 8, 1'b0, 1'b0, 1'b1, 2);
    tick(4);
    check("sb_empty_vote", sb.size(), 0);

    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1);
    tick(4);
    check("sb_empty_b2b", sb.size(), 0);

    prescale = 6'd8;
    RX_IN = 1'b0;
    tick(8);
    for (int i = 0; i < 4; i++) begin
      RX_IN = (8'hC3 >> i) & 8'h01;
      tick(8);
    end
    RX_IN = 1'b1;
    tick(3);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    tick(1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_P_data", {24'd0, P_data}, 32'd0);
    rst = 1'b1;
    tick(20);
    check("sb_empty_abort", sb.size(), 0);

    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1);
    tick(4);
    check("sb_empty_55", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
